// File: rtl/search_control_pkg.sv
// Shared types and constants for the fractional-search sequencing FSM.
package search_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DRAIN   = 3'd2,
        SAD_OUT = 3'd3,
        FIND    = 3'd4,
        RESULT  = 3'd5
    } state_t;

    localparam int DEF_ROWS        = 8;
    localparam int DEF_FIND_CYCLES = 2;
    localparam int SAD_OUT_CYCLES  = 2;

endpackage

// File: rtl/search_control_if.sv
// Control bundle between the search sequencer and its neighbours: the start/busy/done
// handshake, candidate-row qualification, and every search_operative control input.
interface search_control_if
    import search_ctrl_pkg::*;
#(
    parameter int ROWS = DEF_ROWS
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          start;
    logic          cand_valid;
    logic          busy;
    logic          done;
    logic [RW-1:0] row_idx;
    logic          enable;
    logic          reset_right_sads;
    logic          enable_reg_ori;
    logic          enable_tb_ori;
    logic          direction_tb_ori;
    logic          enable_left_side;
    logic          enable_right_side;
    logic          enable_out_sad_tree;
    logic          sel_sad;
    logic          enable_finder;
    logic          enable_out_finder;
    logic          left_or_right;

    // Sequencer side.
    modport master (
        input  start, cand_valid,
        output busy, done, row_idx, enable, reset_right_sads, enable_reg_ori,
               enable_tb_ori, direction_tb_ori, enable_left_side, enable_right_side,
               enable_out_sad_tree, sel_sad, enable_finder, enable_out_finder,
               left_or_right
    );

    // Requester / datapath side.
    modport slave (
        output start, cand_valid,
        input  busy, done, row_idx, enable, reset_right_sads, enable_reg_ori,
               enable_tb_ori, direction_tb_ori, enable_left_side, enable_right_side,
               enable_out_sad_tree, sel_sad, enable_finder, enable_out_finder,
               left_or_right
    );

endinterface

// File: rtl/search_control.sv
// Sequencer for one 8x8 fractional-search block: LOAD original rows, DRAIN the
// transpose buffer, emit SAD-tree outputs, run the finder, capture the result.
// LOAD/DRAIN progress only on cycles with valid candidate rows.
module search_control
    import search_ctrl_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int FIND_CYCLES = DEF_FIND_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    search_control_if.master bus
);

    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PH_MAX = (FIND_CYCLES > SAD_OUT_CYCLES) ? FIND_CYCLES : SAD_OUT_CYCLES;
    localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [PH_W-1:0] SAD_LAST  = PH_W'(SAD_OUT_CYCLES - 1);
    localparam logic [PH_W-1:0] FIND_LAST = PH_W'(FIND_CYCLES - 1);

    state_t          state;
    logic [RW-1:0]   row_cnt;
    logic [PH_W-1:0] ph_cnt;

    // State, row/phase counters and the registered done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row_cnt  <= '0;
            ph_cnt   <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= (state == RESULT);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        row_cnt <= '0;
                        ph_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (bus.cand_valid) begin
                        if (row_cnt == ROW_LAST) begin
                            row_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.cand_valid) begin
                        if (row_cnt == ROW_LAST) begin
                            row_cnt <= '0;
                            ph_cnt  <= '0;
                            state   <= SAD_OUT;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                SAD_OUT: begin
                    if (ph_cnt == SAD_LAST) begin
                        ph_cnt <= '0;
                        state  <= FIND;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                FIND: begin
                    if (ph_cnt == FIND_LAST) begin
                        ph_cnt <= '0;
                        state  <= RESULT;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                RESULT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Busy is a pure state decode so it cannot glitch on cand_valid.
    assign bus.busy = (state != IDLE);

    // Datapath controls decoded from state/counters; LOAD/DRAIN enables are qualified by cand_valid.
    always_comb begin
        bus.row_idx             = '0;
        bus.enable              = 1'b0;
        bus.reset_right_sads    = 1'b0;
        bus.enable_reg_ori      = 1'b0;
        bus.enable_tb_ori       = 1'b0;
        bus.direction_tb_ori    = 1'b0;
        bus.enable_left_side    = 1'b0;
        bus.enable_right_side   = 1'b0;
        bus.enable_out_sad_tree = 1'b0;
        bus.sel_sad             = 1'b0;
        bus.enable_finder       = 1'b0;
        bus.enable_out_finder   = 1'b0;
        bus.left_or_right       = 1'b0;
        case (state)
            LOAD: begin
                bus.row_idx          = row_cnt;
                bus.enable           = bus.cand_valid;
                bus.reset_right_sads = bus.cand_valid && (row_cnt == '0);
                bus.enable_reg_ori   = bus.cand_valid;
                bus.enable_tb_ori    = bus.cand_valid;
                bus.enable_left_side = bus.cand_valid;
            end
            DRAIN: begin
                bus.row_idx           = row_cnt;
                bus.enable            = bus.cand_valid;
                bus.enable_tb_ori     = bus.cand_valid;
                bus.direction_tb_ori  = 1'b1;
                bus.enable_right_side = bus.cand_valid;
                bus.left_or_right     = 1'b1;
            end
            SAD_OUT: begin
                bus.enable              = 1'b1;
                bus.enable_out_sad_tree = 1'b1;
                bus.sel_sad             = ph_cnt[0];
            end
            FIND: begin
                bus.enable        = 1'b1;
                bus.enable_finder = 1'b1;
                bus.left_or_right = 1'b1;
                bus.sel_sad       = ph_cnt[0];
            end
            RESULT: begin
                bus.enable            = 1'b1;
                bus.enable_out_finder = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_search_control.sv
// Bench for search_control: a default (ROWS=8) and a small (ROWS=4) instance,
// driven with scheduled and randomized candidate-valid patterns.
module tb_search_control;
    import search_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    search_control_if #(.ROWS(8)) b8();
    search_control_if #(.ROWS(4)) b4();

    search_control #(.ROWS(8), .FIND_CYCLES(2)) dut8 (.clock(clock), .reset(reset), .bus(b8.master));
    search_control #(.ROWS(4), .FIND_CYCLES(2)) dut4 (.clock(clock), .reset(reset), .bus(b4.master));

    logic [11:0] ctl8, ctl4;
    assign ctl8 = {b8.enable, b8.reset_right_sads, b8.enable_reg_ori, b8.enable_tb_ori,
                   b8.direction_tb_ori, b8.enable_left_side, b8.enable_right_side,
                   b8.enable_out_sad_tree, b8.sel_sad, b8.enable_finder,
                   b8.enable_out_finder, b8.left_or_right};
    assign ctl4 = {b4.enable, b4.reset_right_sads, b4.enable_reg_ori, b4.enable_tb_ori,
                   b4.direction_tb_ori, b4.enable_left_side, b4.enable_right_side,
                   b4.enable_out_sad_tree, b4.sel_sad, b4.enable_finder,
                   b4.enable_out_finder, b4.left_or_right};

    typedef struct { logic cv; logic [11:0] ctl; int row; } exp_t;
    typedef struct { logic [11:0] ctl; int row; logic busy; logic done; } obs_t;

    exp_t sched[$];
    obs_t obs[$];
    int   ld_stall[8];
    int   dr_stall[8];
    int   vectors = 0;
    int   errors  = 0;

    function automatic logic [11:0] mk(bit en, bit rrs, bit rego, bit tbo, bit dir, bit ls,
                                       bit rs, bit ost, bit sel, bit fnd, bit ofd, bit lor);
        return {en, rrs, rego, tbo, dir, ls, rs, ost, sel, fnd, ofd, lor};
    endfunction

    function automatic obs_t sample(int sel);
        obs_t o;
        if (sel == 0) begin
            o.ctl = ctl8; o.row = int'(b8.row_idx); o.busy = b8.busy; o.done = b8.done;
        end else begin
            o.ctl = ctl4; o.row = int'(b4.row_idx); o.busy = b4.busy; o.done = b4.done;
        end
        return o;
    endfunction

    task automatic set_start(int sel, logic v);
        if (sel == 0) b8.start = v; else b4.start = v;
    endtask

    task automatic set_cv(int sel, logic v);
        if (sel == 0) b8.cand_valid = v; else b4.cand_valid = v;
    endtask

    // Expected per-cycle behaviour of one block, phase by phase, from the stall tables.
    function automatic void build(int rows, int fc, bit cv_rand);
        exp_t e;
        sched.delete();
        for (int r = 0; r < rows; r++) begin
            for (int s = 0; s < ld_stall[r]; s++) begin
                e.cv = 1'b0; e.ctl = 12'h000; e.row = r; sched.push_back(e);
            end
            e.cv = 1'b1; e.ctl = mk(1, r == 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); e.row = r;
            sched.push_back(e);
        end
        for (int r = 0; r < rows; r++) begin
            for (int s = 0; s < dr_stall[r]; s++) begin
                e.cv = 1'b0; e.ctl = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1); e.row = r;
                sched.push_back(e);
            end
            e.cv = 1'b1; e.ctl = mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1); e.row = r;
            sched.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            e.cv = cv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            e.ctl = mk(1, 0, 0, 0, 0, 0, 0, 1, k % 2, 0, 0, 0); e.row = 0; sched.push_back(e);
        end
        for (int k = 0; k < fc; k++) begin
            e.cv = cv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            e.ctl = mk(1, 0, 0, 0, 0, 0, 0, 0, k % 2, 1, 0, 1); e.row = 0; sched.push_back(e);
        end
        e.cv = cv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        e.ctl = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e.row = 0; sched.push_back(e);
    endfunction

    function automatic void clear_stalls();
        for (int i = 0; i < 8; i++) begin ld_stall[i] = 0; dr_stall[i] = 0; end
    endfunction

    function automatic void rand_stalls(int rows);
        clear_stalls();
        for (int i = 0; i < rows; i++) begin
            ld_stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            dr_stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
    endfunction

    // Drive one block from sched, recording one observation per cycle into obs.
    // repulse: cycle in which start is re-asserted; abort: cycle in which reset fires.
    task automatic run_block(int sel, bit pre_started, bit chain, int repulse, int abort);
        bit aborted = 1'b0;
        obs.delete();
        if (!pre_started) begin
            @(negedge clock);
            set_start(sel, 1'b1);
        end
        @(posedge clock); #1;
        set_start(sel, 1'b0);
        for (int i = 0; i < sched.size(); i++) begin
            set_cv(sel, sched[i].cv);
            if (repulse == i + 1) set_start(sel, 1'b1);
            if (abort == i + 1) begin
                reset = 1'b1;
                @(negedge clock);
                obs.push_back(sample(sel));
                reset = 1'b0;
                set_cv(sel, 1'b0);
                aborted = 1'b1;
                break;
            end
            @(negedge clock);
            obs.push_back(sample(sel));
            @(posedge clock); #1;
            set_start(sel, 1'b0);
        end
        if (!aborted) begin
            set_cv(sel, 1'($urandom_range(0, 1)));
            @(negedge clock);
            obs.push_back(sample(sel));
            if (chain) begin
                set_start(sel, 1'b1);
            end else begin
                @(posedge clock); #1;
                @(negedge clock);
                obs.push_back(sample(sel));
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        b8.start = 1'b1; b8.cand_valid = 1'b1; b4.start = 1'b1; b4.cand_valid = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            o = sample(s);
            vectors++;
            if (o.ctl !== 12'h000 || o.row != 0 || o.busy !== 1'b0 || o.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold dut%0d ctl=%h row=%0d busy=%b done=%b, want all 0", s, o.ctl, o.row, o.busy, o.done);
            end
        end
        b8.start = 1'b0; b4.start = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            b8.cand_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            o = sample(0);
            vectors++;
            if (o.ctl !== 12'h000 || o.row != 0 || o.busy !== 1'b0 || o.done !== 1'b0) begin
                errors++;
                $display("FAIL idle c%0d ctl=%h row=%0d busy=%b done=%b, want all 0", c, o.ctl, o.row, o.busy, o.done);
            end
        end
    endtask

    task automatic test_nominal();
        int n;
        clear_stalls();
        build(8, 2, 1'b0);
        n = sched.size();
        run_block(0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].busy !== 1'b1 || obs[i].done !== 1'b0) begin
                errors++;
                $display("FAIL nominal cycle %0d: ctl=%h row=%0d busy=%b done=%b, want ctl=%h row=%0d busy=1 done=0",
                         i + 1, obs[i].ctl, obs[i].row, obs[i].busy, obs[i].done, sched[i].ctl, sched[i].row);
            end
        end
        vectors++;
        if (obs[n].done !== 1'b1 || obs[n].busy !== 1'b0 || obs[n].ctl !== 12'h000) begin
            errors++;
            $display("FAIL nominal_done cycle %0d: done=%b busy=%b ctl=%h, want done=1 busy=0 ctl=000", n + 1, obs[n].done, obs[n].busy, obs[n].ctl);
        end
        vectors++;
        if (obs[n+1].done !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done_pulse: done=%b one cycle later, want 0", obs[n+1].done);
        end
    endtask

    task automatic test_stall();
        int n;
        clear_stalls();
        ld_stall[4] = 3;
        dr_stall[0] = 2;
        build(8, 2, 1'b0);
        n = sched.size();
        run_block(0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].busy !== 1'b1 || obs[i].done !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: ctl=%h row=%0d busy=%b done=%b, want ctl=%h row=%0d busy=1 done=0",
                         i + 1, obs[i].ctl, obs[i].row, obs[i].busy, obs[i].done, sched[i].ctl, sched[i].row);
            end
        end
        vectors++;
        if (obs[n].done !== 1'b1 || obs[n].busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done cycle %0d: done=%b busy=%b, want done=1 busy=0 (cycle 27)", n + 1, obs[n].done, obs[n].busy);
        end
    endtask

    task automatic test_repulse();
        int n;
        clear_stalls();
        build(8, 2, 1'b1);
        n = sched.size();
        run_block(0, 1'b0, 1'b0, 10, 0);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].done !== 1'b0) begin
                errors++;
                $display("FAIL repulse cycle %0d: ctl=%h row=%0d done=%b, want ctl=%h row=%0d done=0",
                         i + 1, obs[i].ctl, obs[i].row, obs[i].done, sched[i].ctl, sched[i].row);
            end
        end
        vectors++;
        if (obs[n].done !== 1'b1) begin
            errors++;
            $display("FAIL repulse_done: done=%b at cycle %0d, want 1", obs[n].done, n + 1);
        end
        vectors++;
        if (obs[n+1].done !== 1'b0 || obs[n+1].busy !== 1'b0) begin
            errors++;
            $display("FAIL repulse_single: done=%b busy=%b after first done, want 0/0", obs[n+1].done, obs[n+1].busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int blk = 0; blk < 2; blk++) begin
            clear_stalls();
            build(8, 2, 1'b1);
            n = sched.size();
            run_block(0, blk == 1, blk == 0, 0, 0);
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].busy !== 1'b1 || obs[i].done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b blk%0d cycle %0d: ctl=%h row=%0d busy=%b done=%b, want ctl=%h row=%0d busy=1 done=0",
                             blk, i + 1, obs[i].ctl, obs[i].row, obs[i].busy, obs[i].done, sched[i].ctl, sched[i].row);
                end
            end
            vectors++;
            if (obs[n].done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done blk%0d: done=%b at cycle %0d, want 1", blk, obs[n].done, n + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        clear_stalls();
        build(8, 2, 1'b0);
        run_block(0, 1'b0, 1'b0, 0, 12);
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row) begin
                errors++;
                $display("FAIL pre_abort cycle %0d: ctl=%h row=%0d, want ctl=%h row=%0d",
                         i + 1, obs[i].ctl, obs[i].row, sched[i].ctl, sched[i].row);
            end
        end
        vectors++;
        if (obs[11].ctl !== 12'h000 || obs[11].row != 0 || obs[11].busy !== 1'b0 || obs[11].done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: ctl=%h row=%0d busy=%b done=%b, want all 0", obs[11].ctl, obs[11].row, obs[11].busy, obs[11].done);
        end
        for (int c = 0; c < 25; c++) begin
            b8.cand_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            o = sample(0);
            vectors++;
            if (o.done !== 1'b0 || o.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c%0d: done=%b busy=%b, want 0/0", c, o.done, o.busy);
            end
        end
        test_nominal();
    endtask

    task automatic test_param_small();
        int n;
        clear_stalls();
        build(4, 2, 1'b0);
        n = sched.size();
        run_block(1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].busy !== 1'b1 || obs[i].done !== 1'b0) begin
                errors++;
                $display("FAIL rows4 cycle %0d: ctl=%h row=%0d busy=%b done=%b, want ctl=%h row=%0d busy=1 done=0",
                         i + 1, obs[i].ctl, obs[i].row, obs[i].busy, obs[i].done, sched[i].ctl, sched[i].row);
            end
        end
        vectors++;
        if (obs[n].done !== 1'b1 || obs[n].busy !== 1'b0) begin
            errors++;
            $display("FAIL rows4_done cycle %0d: done=%b busy=%b, want done=1 busy=0 (cycle 14)", n + 1, obs[n].done, obs[n].busy);
        end
    endtask

    task automatic test_random();
        int n;
        int sel;
        for (int blk = 0; blk < 6; blk++) begin
            sel = (blk % 3 == 2) ? 1 : 0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            rand_stalls(sel ? 4 : 8);
            build(sel ? 4 : 8, 2, 1'b1);
            n = sched.size();
            run_block(sel, 1'b0, 1'b0, 0, 0);
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (obs[i].ctl !== sched[i].ctl || obs[i].row != sched[i].row || obs[i].busy !== 1'b1 || obs[i].done !== 1'b0) begin
                    errors++;
                    $display("FAIL random blk%0d dut%0d cycle %0d: ctl=%h row=%0d busy=%b done=%b, want ctl=%h row=%0d busy=1 done=0",
                             blk, sel, i + 1, obs[i].ctl, obs[i].row, obs[i].busy, obs[i].done, sched[i].ctl, sched[i].row);
                end
            end
            vectors++;
            if (obs[n].done !== 1'b1 || obs[n].busy !== 1'b0 || obs[n+1].done !== 1'b0) begin
                errors++;
                $display("FAIL random_done blk%0d: done=%b busy=%b next_done=%b, want 1/0/0", blk, obs[n].done, obs[n].busy, obs[n+1].done);
            end
        end
    endtask

    initial begin
        b8.start = 1'b0; b8.cand_valid = 1'b0;
        b4.start = 1'b0; b4.cand_valid = 1'b0;
        test_reset();
        test_nominal();
        test_stall();
        test_repulse();
        test_back_to_back();
        test_reset_mid();
        test_param_small();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
